// File: rtl/edge_pulse_pkg.sv
// Shared definitions for the edge pulse generator: mode encodings, pulse FSM states
// and the edge-qualification rule used by every channel.
package edge_pulse_pkg;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } pulse_state_t;

    function automatic logic edge_qualifies(
        input logic [1:0] mode,
        input logic       rise,
        input logic       fall
    );
        case (mode)
            MODE_RISE: return rise;
            MODE_FALL: return fall;
            MODE_BOTH: return rise | fall;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/edge_pulse_chan.sv
// One channel: 2-flop sync, debounce, edge qualify, PULSE_W-wide one-shot (auto-repeat under EDGE_PULSE_AUTO_REPEAT_EN).
// Latency: trigger sampled at edge k -> level at k+1+DEB_CYCLES, out_pulse at k+2+DEB_CYCLES.
// Backpressure: none; free-running, every accepted edge is acted on.
module edge_pulse_chan
    import edge_pulse_pkg::*;
#(
    parameter int DEB_CYCLES    = 4,
    parameter int PULSE_W       = 1,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_trig,
    input  logic [1:0] mode,
    output logic       out_pulse,
    output logic       level
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int WW = $clog2(PULSE_W + 1);

    logic          s1;
    logic          s2;
    logic [DW-1:0] dcnt;
    logic          level_prev;
    pulse_state_t  state;
    logic [WW-1:0] wcnt;
    logic          edge_hit;
    logic          rep_fire;
    logic          qualify;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            level      <= 1'b0;
            level_prev <= 1'b0;
            dcnt       <= '0;
        end else begin
            s1         <= in_trig;
            s2         <= s1;
            level_prev <= level;
            // Any return to the current level before acceptance restarts the count.
            if (s2 == level) begin
                dcnt <= '0;
            end else if (dcnt == DW'(DEB_CYCLES - 1)) begin
                level <= s2;
                dcnt  <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    // Edge is seen the cycle after level moves, which is where the extra clock of latency comes from.
    assign edge_hit = edge_qualifies(mode, level & ~level_prev, ~level & level_prev);
    assign qualify  = edge_hit | rep_fire;

`ifdef EDGE_PULSE_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rcnt;
    logic          rphase;
    logic          rep_ok;
    logic [RW-1:0] rtarget;

    assign rep_ok   = level & ((mode == MODE_RISE) | (mode == MODE_BOTH));
    assign rtarget  = rphase ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
    assign rep_fire = rep_ok & (rcnt == rtarget);

    // First target is the hold delay, afterwards the repeat period.
    always_ff @(posedge clk) begin
        if (!rst_n || !rep_ok) begin
            rcnt   <= '0;
            rphase <= 1'b0;
        end else if (rep_fire) begin
            rcnt   <= RW'(1);
            rphase <= 1'b1;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end
`else
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat_cfg
        assign rep_fire = 1'b0;
    end else begin : g_no_repeat
        assign rep_fire = 1'b0;
    end
`endif

    // A qualify while ACTIVE reloads the width, stretching the pulse instead of splitting it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wcnt      <= '0;
            out_pulse <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (qualify) begin
                        state     <= ACTIVE;
                        wcnt      <= WW'(PULSE_W - 1);
                        out_pulse <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (qualify) begin
                        wcnt <= WW'(PULSE_W - 1);
                    end else if (wcnt != '0) begin
                        wcnt <= wcnt - 1'b1;
                    end else begin
                        state     <= IDLE;
                        out_pulse <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_pulse <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/edge_pulse_gen.sv
// N_CH independent debounced edge-to-pulse channels sharing one mode (auto-repeat under EDGE_PULSE_AUTO_REPEAT_EN).
// Latency: trigger sampled at edge k -> level at k+1+DEB_CYCLES, out_pulse at k+2+DEB_CYCLES.
// Backpressure: none; outputs are registered one-shots with no handshake.
module edge_pulse_gen
    import edge_pulse_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int DEB_CYCLES    = 4,
    parameter int PULSE_W       = 1,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] in_trig,
    input  logic [1:0]      mode,
    output logic [N_CH-1:0] out_pulse,
    output logic [N_CH-1:0] level
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_pulse_chan #(
            .DEB_CYCLES   (DEB_CYCLES),
            .PULSE_W      (PULSE_W),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_trig  (in_trig[i]),
            .mode     (mode),
            .out_pulse(out_pulse[i]),
            .level    (level[i])
        );
    end

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Directed bench for edge_pulse_gen: two instances (PULSE_W=2 and PULSE_W=8) on shared stimulus.
module tb_edge_pulse_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_trig = 4'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] pulse2, level2, pulse8, level8;
    logic [3:0] lvl_m = 4'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    edge_pulse_gen #(.N_CH(4), .DEB_CYCLES(4), .PULSE_W(2), .REPEAT_DELAY(20), .REPEAT_PERIOD(10)) dut (
        .clk(clk), .rst_n(rst_n), .in_trig(in_trig), .mode(mode), .out_pulse(pulse2), .level(level2)
    );

    edge_pulse_gen #(.N_CH(4), .DEB_CYCLES(4), .PULSE_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_trig(in_trig), .mode(mode), .out_pulse(pulse8), .level(level8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one channel to val and follow the 9 clocks of debounce + pulse on the PULSE_W=2 instance.
    task automatic edge_run(input int ch, input logic val, input logic pulse_on, input string tag);
        logic [3:0] nl;
        logic [3:0] ep;
        nl = lvl_m;
        nl[ch] = val;
        in_trig[ch] = val;
        for (int d = 0; d < 9; d++) begin
            step();
            chk({tag, "_lvl"}, level2, (d >= 5) ? nl : lvl_m);
            ep = 4'b0;
            if (pulse_on && (d == 6 || d == 7)) ep[ch] = 1'b1;
            chk({tag, "_out"}, pulse2, ep);
        end
        lvl_m = nl;
    endtask

    initial begin
        logic [3:0] e2, e8, el;

        repeat (3) step();
        chk("rst_out2", pulse2, 4'b0);
        chk("rst_lvl2", level2, 4'b0);
        chk("rst_out8", pulse8, 4'b0);
        chk("rst_lvl8", level8, 4'b0);
        rst_n = 1'b1;
        step();

        // Rise on ch0 in rise mode, then a fall that must not pulse.
        mode = 2'b00;
        edge_run(0, 1'b1, 1'b1, "t1_rise");
        edge_run(0, 1'b0, 1'b0, "t1_fall");

        // 3-clock glitch on ch1 is rejected.
        in_trig[1] = 1'b1;
        repeat (3) step();
        in_trig[1] = 1'b0;
        for (int d = 0; d < 9; d++) begin
            step();
            chk("t2_lvl", level2, 4'b0);
            chk("t2_out", pulse2, 4'b0);
        end

        // Fall, both and off modes on ch2.
        mode = 2'b01;
        edge_run(2, 1'b1, 1'b0, "t3_fall_press");
        repeat (11) step();
        edge_run(2, 1'b0, 1'b1, "t3_fall_rel");
        mode = 2'b10;
        edge_run(2, 1'b1, 1'b1, "t3_both_press");
        edge_run(2, 1'b0, 1'b1, "t3_both_rel");
        mode = 2'b11;
        edge_run(2, 1'b1, 1'b0, "t3_off_press");
        edge_run(2, 1'b0, 1'b0, "t3_off_rel");
        repeat (12) step();
        chk("t4_pre_out8", pulse8, 4'b0);
        chk("t4_pre_lvl8", level8, lvl_m);

        // Same-cycle rises on ch1/ch3; ch1 held exactly 4 samples, its fall re-qualifies while ACTIVE.
        mode = 2'b10;
        in_trig[1] = 1'b1;
        in_trig[3] = 1'b1;
        for (int d = 0; d < 20; d++) begin
            step();
            e8 = {(d >= 6 && d <= 13), 1'b0, (d >= 6 && d <= 17), 1'b0};
            e2 = {(d == 6 || d == 7), 1'b0, (d == 6 || d == 7 || d == 10 || d == 11), 1'b0};
            el = {(d >= 5), 1'b0, (d >= 5 && d <= 8), 1'b0};
            chk("t4_out8", pulse8, e8);
            chk("t4_out2", pulse2, e2);
            chk("t4_lvl8", level8, el);
            if (d == 3) in_trig[1] = 1'b0;
        end
        mode = 2'b00;
        in_trig = 4'b0;
        repeat (20) step();
        lvl_m = 4'b0;
        chk("t4_post_lvl", level2, 4'b0);
        chk("t4_post_out2", pulse2, 4'b0);
        chk("t4_post_out8", pulse8, 4'b0);

        // Reset mid-pulse with ch0 held high; rise reappears after release.
        in_trig[0] = 1'b1;
        for (int d = 0; d <= 6; d++) step();
        chk("t5_active2", pulse2, 4'b0001);
        chk("t5_active8", pulse8, 4'b0001);
        rst_n = 1'b0;
        step();
        chk("t5_rst_out2", pulse2, 4'b0);
        chk("t5_rst_lvl2", level2, 4'b0);
        chk("t5_rst_out8", pulse8, 4'b0);
        chk("t5_rst_lvl8", level8, 4'b0);
        rst_n = 1'b1;
        for (int d = 0; d < 10; d++) begin
            step();
            chk("t5_lvl2", level2, (d >= 5) ? 4'b0001 : 4'b0000);
            chk("t5_out2", pulse2, (d == 6 || d == 7) ? 4'b0001 : 4'b0000);
            chk("t5_out8", pulse8, (d >= 6) ? 4'b0001 : 4'b0000);
        end
        in_trig = 4'b0;
        repeat (14) step();
        chk("t5_post_lvl", level2, 4'b0);
        chk("t5_post_out2", pulse2, 4'b0);

`ifdef EDGE_PULSE_AUTO_REPEAT_EN
        // ch0 held 60 samples: pulses at accept+1, +21, +31, +41, +51, none after release.
        mode = 2'b00;
        in_trig[0] = 1'b1;
        for (int d = 0; d < 76; d++) begin
            step();
            chk("t6_out2", pulse2,
                (d == 6 || d == 7 || (d >= 26 && d <= 57 && ((d - 26) % 10) < 2)) ? 4'b0001 : 4'b0000);
            if (d == 59) in_trig[0] = 1'b0;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
